// File: rtl/day3_debounce.sv
// day3_debounce: synchronizer, consecutive-sample debouncer FSM,
// registered level, rise/fall pulses and a wrapping rise counter.
module day3_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] rise_cnt_o
);

  typedef enum logic [1:0] {
    LO,
    CHK_HI,
    HI,
    CHK_LO
  } state_t;

  localparam int CW =
    (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sh_q, sh_d;
  logic                   sync_q;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_W-1:0]       rcnt_q, rcnt_d;

  assign sync_q = sh_q[SYNC_STAGES-1];
  assign sh_d   = {sh_q[SYNC_STAGES-2:0], raw_i};

  // Next state: qualify a level change only after enough equal samples
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      LO: begin
        if (sync_q && SINGLE) begin
          state_d = HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else if (sync_q) begin
          state_d = CHK_HI;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      CHK_HI: begin
        if (!sync_q) begin
          state_d = LO;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HI: begin
        if (!sync_q && SINGLE) begin
          state_d = LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else if (!sync_q) begin
          state_d = CHK_LO;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      CHK_LO: begin
        if (sync_q) begin
          state_d = HI;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
    if (rise_d) rcnt_d = rcnt_q + 1'b1;
  end

  // State, synchronizer and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q    <= '0;
      state_q <= LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      sh_q    <= sh_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign rise_cnt_o = rcnt_q;

endmodule

// File: tb/tb_day3_debounce.sv
// tb_day3_debounce: directed checks of debounce latency, glitch
// rejection, async reset, counter wrap and single-sample mode.
module tb_day3_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic       rst_a, raw_a, lvl_a, rise_a, fall_a;
  logic [7:0] cnt_a;
  logic       rst_b, raw_b, lvl_b, rise_b, fall_b;
  logic [1:0] cnt_b;
  logic       rst_c, raw_c, lvl_c, rise_c, fall_c;
  logic [7:0] cnt_c;

  day3_debounce u_a (
    .clk(clk), .reset(rst_a), .raw_i(raw_a),
    .level_o(lvl_a), .rise_o(rise_a), .fall_o(fall_a),
    .rise_cnt_o(cnt_a)
  );

  day3_debounce #(.CNT_W(2)) u_b (
    .clk(clk), .reset(rst_b), .raw_i(raw_b),
    .level_o(lvl_b), .rise_o(rise_b), .fall_o(fall_b),
    .rise_cnt_o(cnt_b)
  );

  day3_debounce #(.DEBOUNCE_CYCLES(1)) u_c (
    .clk(clk), .reset(rst_c), .raw_i(raw_c),
    .level_o(lvl_c), .rise_o(rise_c), .fall_o(fall_c),
    .rise_cnt_o(cnt_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; raw_a = 1'b1;
    rst_b = 1'b1; raw_b = 1'b0;
    rst_c = 1'b1; raw_c = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_assert++;
      if ({lvl_a, rise_a, fall_a, cnt_a} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_vals cyc%0d got l=%b r=%b f=%b c=%0d want 0",
                 i, lvl_a, rise_a, fall_a, cnt_a);
      end
      if (i < 2) tick();
    end
  endtask

  task automatic test_rise_fall();
    rst_a = 1'b0;
    raw_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_assert++;
      if (lvl_a !== 1'b0 || rise_a !== 1'b0) begin
        n_fail++;
        $display("FAIL rise_early E0+%0d got l=%b r=%b want 0 0",
                 k, lvl_a, rise_a);
      end
    end
    tick();
    n_assert++;
    if (lvl_a !== 1'b1 || rise_a !== 1'b1 || cnt_a !== 8'd1) begin
      n_fail++;
      $display("FAIL rise_edge got l=%b r=%b c=%0d want 1 1 1",
               lvl_a, rise_a, cnt_a);
    end
    tick();
    n_assert++;
    if (lvl_a !== 1'b1 || rise_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_drop got l=%b r=%b want 1 0", lvl_a, rise_a);
    end
    raw_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_assert++;
      if (lvl_a !== 1'b1 || fall_a !== 1'b0) begin
        n_fail++;
        $display("FAIL fall_early E0+%0d got l=%b f=%b want 1 0",
                 k, lvl_a, fall_a);
      end
    end
    tick();
    n_assert++;
    if (lvl_a !== 1'b0 || fall_a !== 1'b1 || cnt_a !== 8'd1 ||
        rise_a !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_edge got l=%b f=%b r=%b c=%0d want 0 1 0 1",
               lvl_a, fall_a, rise_a, cnt_a);
    end
    tick();
    n_assert++;
    if (fall_a !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_drop got f=%b want 0", fall_a);
    end
  endtask

  task automatic test_glitch();
    raw_a = 1'b1;
    tick(); tick(); tick();
    raw_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_assert++;
      if (lvl_a !== 1'b0 || rise_a !== 1'b0 || fall_a !== 1'b0 ||
          cnt_a !== 8'd1) begin
        n_fail++;
        $display("FAIL glitch_hi k%0d got l=%b r=%b f=%b c=%0d want 0 0 0 1",
                 k, lvl_a, rise_a, fall_a, cnt_a);
      end
    end
    raw_a = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    n_assert++;
    if (lvl_a !== 1'b1 || cnt_a !== 8'd2) begin
      n_fail++;
      $display("FAIL dip_setup got l=%b c=%0d want 1 2", lvl_a, cnt_a);
    end
    raw_a = 1'b0;
    tick(); tick(); tick();
    raw_a = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_assert++;
      if (lvl_a !== 1'b1 || fall_a !== 1'b0 || rise_a !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_lo k%0d got l=%b f=%b r=%b want 1 0 0",
                 k, lvl_a, fall_a, rise_a);
      end
    end
  endtask

  task automatic test_reset_mid();
    raw_a = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    raw_a = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    n_assert++;
    if ({lvl_a, rise_a, fall_a, cnt_a} !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_async got l=%b r=%b f=%b c=%0d want 0",
               lvl_a, rise_a, fall_a, cnt_a);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_assert++;
      if ({lvl_a, rise_a, fall_a, cnt_a} !== 11'd0) begin
        n_fail++;
        $display("FAIL rst_hold k%0d got l=%b r=%b c=%0d want 0",
                 k, lvl_a, rise_a, cnt_a);
      end
    end
    rst_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_assert++;
      if (rise_a !== 1'b0 || lvl_a !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_requal E0+%0d got r=%b l=%b want 0 0",
                 k, rise_a, lvl_a);
      end
    end
    tick();
    n_assert++;
    if (rise_a !== 1'b1 || lvl_a !== 1'b1 || cnt_a !== 8'd1) begin
      n_fail++;
      $display("FAIL rst_rise got r=%b l=%b c=%0d want 1 1 1",
               rise_a, lvl_a, cnt_a);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_w [5];
    exp_w = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      raw_b = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      n_assert++;
      if (rise_b !== 1'b1 || cnt_b !== exp_w[i]) begin
        n_fail++;
        $display("FAIL wrap n%0d got r=%b c=%0d want 1 %0d",
                 i, rise_b, cnt_b, exp_w[i]);
      end
      raw_b = 1'b0;
      for (int k = 0; k < 7; k++) tick();
    end
  endtask

  task automatic test_single();
    int nr, nf;
    rst_c = 1'b0;
    raw_c = 1'b1;
    tick(); tick();
    n_assert++;
    if (rise_c !== 1'b0) begin
      n_fail++;
      $display("FAIL d1_early got r=%b want 0", rise_c);
    end
    tick();
    n_assert++;
    if (rise_c !== 1'b1 || lvl_c !== 1'b1) begin
      n_fail++;
      $display("FAIL d1_rise got r=%b l=%b want 1 1", rise_c, lvl_c);
    end
    raw_c = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    raw_c = 1'b1;
    tick();
    raw_c = 1'b0;
    nr = 0;
    nf = 0;
    for (int k = 1; k < 8; k++) begin
      tick();
      if (rise_c) nr++;
      if (fall_c) nf++;
      if (k == 2) begin
        n_assert++;
        if (rise_c !== 1'b1 || fall_c !== 1'b0) begin
          n_fail++;
          $display("FAIL d1_gl_rise got r=%b f=%b want 1 0", rise_c, fall_c);
        end
      end
      if (k == 3) begin
        n_assert++;
        if (fall_c !== 1'b1 || rise_c !== 1'b0) begin
          n_fail++;
          $display("FAIL d1_gl_fall got f=%b r=%b want 1 0", fall_c, rise_c);
        end
      end
    end
    n_assert++;
    if (nr != 1 || nf != 1 || cnt_c !== 8'd2) begin
      n_fail++;
      $display("FAIL d1_counts got rises=%0d falls=%0d c=%0d want 1 1 2",
               nr, nf, cnt_c);
    end
  endtask

  initial begin
    test_reset();
    test_rise_fall();
    test_glitch();
    test_reset_mid();
    test_wrap();
    test_single();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
